// File: rtl/kfsdram_burst_bridge.sv
// Host-side burst adapter for the KFSDRAM controller: buffers one write burst, issues fixed-length
// bursts, collects read data. Optional watchdog abort enabled by defining KFSDRAM_BRIDGE_TIMEOUT_EN.
//   state   | meaning
//   B_IDLE  | waiting for a host command; buffers fill/drain freely
//   B_REQ   | request held until controller reports idle
//   B_WRITE | controller consuming write buffer on write_flag
//   B_READ  | controller filling read buffer on read_flag
module kfsdram_burst_bridge #(
  parameter int          COL_WIDTH  = 10,
  parameter int          ROW_WIDTH  = 13,
  parameter int          BANK_WIDTH = 2,
  parameter int          DATA_WIDTH = 16,
  parameter int          BURST_LEN  = 8,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input  logic                                     sdram_clock,
  input  logic                                     sdram_reset,
  input  logic                                     host_cmd_valid,
  output logic                                     host_cmd_ready,
  input  logic                                     host_cmd_write,
  input  logic [COL_WIDTH+ROW_WIDTH+BANK_WIDTH-1:0] host_cmd_address,
  input  logic [DATA_WIDTH-1:0]                    host_wdata,
  input  logic                                     host_wvalid,
  output logic                                     host_wready,
  output logic [DATA_WIDTH-1:0]                    host_rdata,
  output logic                                     host_rvalid,
  input  logic                                     host_rready,
  output logic                                     busy,
  output logic                                     bridge_error,
  output logic [COL_WIDTH+ROW_WIDTH+BANK_WIDTH-1:0] ctrl_address,
  output logic [COL_WIDTH-1:0]                     ctrl_access_num,
  output logic [DATA_WIDTH-1:0]                    ctrl_data_in,
  output logic                                     ctrl_write_request,
  output logic                                     ctrl_read_request,
  input  logic [DATA_WIDTH-1:0]                    ctrl_data_out,
  input  logic                                     ctrl_write_flag,
  input  logic                                     ctrl_read_flag,
  input  logic                                     ctrl_idle
);

  localparam int ADDR_W = COL_WIDTH + ROW_WIDTH + BANK_WIDTH;
  localparam int PTR_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  FULL       = CNT_W'(BURST_LEN);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {B_IDLE, B_REQ, B_WRITE, B_READ} state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    wcount_q, wcount_d, rcount_q, rcount_d, rbeat_q, rbeat_d;
  logic [PTR_W-1:0]    w_in_q, w_in_d, w_out_q, w_out_d, r_in_q, r_in_d, r_out_q, r_out_d;
  logic [DATA_WIDTH-1:0] wbuf [BURST_LEN];
  logic [DATA_WIDTH-1:0] rbuf [BURST_LEN];
  logic                w_push, w_pop, r_push, r_pop, cmd_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign busy               = state_q != B_IDLE;
  assign host_wready        = (wcount_q < FULL) && (state_q != B_WRITE);
  assign host_cmd_ready     = (state_q == B_IDLE) && (host_cmd_write ? (wcount_q == FULL) : (rcount_q == '0));
  assign host_rvalid        = rcount_q != '0;
  assign host_rdata         = host_rvalid ? rbuf[r_out_q] : '0;
  assign ctrl_data_in       = (state_q == B_WRITE) ? wbuf[w_out_q] : '0;
  assign ctrl_write_request = (state_q == B_REQ) && write_q;
  assign ctrl_read_request  = (state_q == B_REQ) && !write_q;
  assign ctrl_address       = addr_q;
  assign ctrl_access_num    = COL_WIDTH'(BURST_LEN);

  assign cmd_fire = host_cmd_valid && host_cmd_ready;
  assign w_push   = host_wvalid && host_wready;
  assign w_pop    = (state_q == B_WRITE) && ctrl_write_flag && (wcount_q != '0);
  // Beats past BURST_LEN are dropped even if the host drains concurrently.
  assign r_push   = (state_q == B_READ) && ctrl_read_flag && (rbeat_q < FULL);
  assign r_pop    = host_rvalid && host_rready;

`ifdef KFSDRAM_BRIDGE_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
  assign bridge_error = err_q;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign bridge_error   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wcount_d = wcount_q + CNT_W'(w_push) - CNT_W'(w_pop);
    rcount_d = rcount_q + CNT_W'(r_push) - CNT_W'(r_pop);
    rbeat_d  = r_push ? rbeat_q + CNT_W'(1) : rbeat_q;
    w_in_d   = w_push ? ptr_inc(w_in_q) : w_in_q;
    w_out_d  = w_pop ? ptr_inc(w_out_q) : w_out_q;
    r_in_d   = r_push ? ptr_inc(r_in_q) : r_in_q;
    r_out_d  = r_pop ? ptr_inc(r_out_q) : r_out_q;
    case (state_q)
      B_IDLE: if (cmd_fire) begin
        write_d = host_cmd_write;
        addr_d  = host_cmd_address & ALIGN_MASK;
        rbeat_d = '0;
        state_d = B_REQ;
      end
      B_REQ:   if (ctrl_idle) state_d = write_q ? B_WRITE : B_READ;
      B_WRITE: if (ctrl_idle) state_d = B_IDLE;
      B_READ:  if (ctrl_idle) state_d = B_IDLE;
      default: state_d = B_IDLE;
    endcase
`ifdef KFSDRAM_BRIDGE_TIMEOUT_EN
    err_d = 1'b0;
    wd_d  = (state_q == B_IDLE || state_d != state_q) ? '0 : wd_q + 16'd1;
    if (state_q != B_IDLE && wd_q == TIMEOUT - 16'd1) begin
      state_d  = B_IDLE;
      wcount_d = '0;
      rcount_d = '0;
      rbeat_d  = '0;
      w_in_d   = '0;
      w_out_d  = '0;
      r_in_d   = '0;
      r_out_d  = '0;
      wd_d     = '0;
      err_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge sdram_clock) begin
    if (!sdram_reset) begin
      state_q  <= B_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wcount_q <= '0;
      rcount_q <= '0;
      rbeat_q  <= '0;
      w_in_q   <= '0;
      w_out_q  <= '0;
      r_in_q   <= '0;
      r_out_q  <= '0;
`ifdef KFSDRAM_BRIDGE_TIMEOUT_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wcount_q <= wcount_d;
      rcount_q <= rcount_d;
      rbeat_q  <= rbeat_d;
      w_in_q   <= w_in_d;
      w_out_q  <= w_out_d;
      r_in_q   <= r_in_d;
      r_out_q  <= r_out_d;
`ifdef KFSDRAM_BRIDGE_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  // Buffer storage carries no reset; contents are don't-care until written.
  always_ff @(posedge sdram_clock) begin
    if (w_push) wbuf[w_in_q] <= host_wdata;
    if (r_push) rbuf[r_in_q] <= ctrl_data_out;
  end

endmodule
